// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase scheduler:
// phase codes, FSM state encoding, requester indices and a mod-5 helper.
package traffic_pkg;

   // Phase codes presented to the light sequencer
   localparam logic [2:0] PH_MAIN_GO     = 3'd0;
   localparam logic [2:0] PH_MAIN_ARROW  = 3'd1;
   localparam logic [2:0] PH_CROSS_ARROW = 3'd2;
   localparam logic [2:0] PH_CROSS_GO    = 3'd3;
   localparam logic [2:0] PH_MAIN_WALK   = 3'd4;
   localparam logic [2:0] PH_CROSS_WALK  = 3'd5;
   localparam logic [2:0] PH_ALL_STOP    = 3'd7;

   // Requester indices into req_in / pending; service phase = index + 1
   localparam int REQ_LEFT_MAIN  = 0;
   localparam int REQ_LEFT_CROSS = 1;
   localparam int REQ_CROSS      = 2;
   localparam int REQ_WALK_MAIN  = 3;
   localparam int REQ_WALK_CROSS = 4;

   typedef enum logic [1:0] {
      MAIN_HOLD = 2'd0,
      ISSUE     = 2'd1,
      SERVE     = 2'd2,
      ALL_RED   = 2'd3
   } state_t;

   // Fold a sum of two values in 0..4 back into 0..4
   function automatic logic [2:0] wrap5(input logic [3:0] s);
      logic [3:0] r;
      r = (s >= 4'd5) ? (s - 4'd5) : s;
      return r[2:0];
   endfunction

endpackage

// File: rtl/phase_scheduler_if.sv
// Grant handshake between the phase scheduler and the light sequencer.
// Handshake: the scheduler raises phase_valid with a stable phase code and
// holds both until the sequencer answers phase_ack=1 in a cycle where
// phase_valid=1; that edge is the transfer. The sequencer later pulses
// phase_done for one cycle when the served phase (including yellow) ends.
interface phase_scheduler_if;
   logic [2:0] phase;
   logic       phase_valid;
   logic       phase_ack;
   logic       phase_done;

   modport master (output phase, output phase_valid,
                   input  phase_ack, input phase_done);
   modport slave  (input  phase, input phase_valid,
                   output phase_ack, output phase_done);
endinterface

// File: rtl/rr_arbiter5.sv
// Five-way round-robin priority pick: first set request found searching
// ptr, ptr+1, ... wrapping modulo 5.
module rr_arbiter5
   import traffic_pkg::*;
(
   input  logic [4:0] req,
   input  logic [2:0] ptr,
   output logic [2:0] gnt_idx,
   output logic       any
);

   logic [2:0] idx;

   // Scan the five positions from ptr and keep the first hit
   always_comb begin
      gnt_idx = 3'd0;
      any     = 1'b0;
      idx     = 3'd0;
      for (int i = 0; i < 5; i++) begin
         idx = wrap5({1'b0, ptr} + 4'(i));
         if (!any && req[idx]) begin
            gnt_idx = idx;
            any     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/phase_scheduler.sv
// Intersection phase scheduler: latches sensor requests, holds main green
// for a minimum time, grants one service phase at a time round-robin, and
// inserts an all-red clearance before main green returns.
module phase_scheduler
   import traffic_pkg::*;
#(
   parameter int MIN_MAIN_S = 6,
   parameter int ALLRED_S   = 3,
   parameter int N_REQ      = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic [N_REQ-1:0] req_in,
   phase_scheduler_if.master sif,
   output logic [N_REQ-1:0] pending,
   output logic             busy,
   output state_t           dbg_state,
   output logic [3:0]       dbg_cnt,
   output logic [2:0]       dbg_rr_ptr
);

   state_t           state, state_nx;
   logic [3:0]       cnt, cnt_nx;
   logic [2:0]       rr_ptr, rr_ptr_nx;
   logic [2:0]       grant, grant_nx;
   logic [N_REQ-1:0] pending_nx;
   logic [2:0]       arb_idx;
   logic             arb_any;

   rr_arbiter5 u_arb (
      .req     (pending),
      .ptr     (rr_ptr),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

   // State, counter, pointer, grant and request latch registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= MAIN_HOLD;
         cnt     <= 4'(MIN_MAIN_S);
         rr_ptr  <= 3'd0;
         grant   <= 3'd0;
         pending <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         rr_ptr  <= rr_ptr_nx;
         grant   <= grant_nx;
         pending <= pending_nx;
      end
   end

   // Next-state logic; a tick only decrements the counter of the state that
   // is not transitioning, so a freshly loaded count is never cut short.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      rr_ptr_nx  = rr_ptr;
      grant_nx   = grant;
      pending_nx = pending | req_in;
      case (state)
         MAIN_HOLD: begin
            if (cnt == 4'd0) begin
               if (arb_any) begin
                  state_nx = ISSUE;
                  grant_nx = arb_idx;
               end
            end else if (tick) begin
               cnt_nx = cnt - 4'd1;
            end
         end
         ISSUE: begin
            if (sif.phase_ack) state_nx = SERVE;
         end
         SERVE: begin
            if (sif.phase_done) begin
               pending_nx[grant] = 1'b0;  // clear wins over a same-cycle set
               rr_ptr_nx         = wrap5({1'b0, grant} + 4'd1);
               cnt_nx            = 4'(ALLRED_S);
               state_nx          = ALL_RED;
            end
         end
         ALL_RED: begin
            if (cnt == 4'd0) begin
               state_nx = MAIN_HOLD;
               cnt_nx   = 4'(MIN_MAIN_S);
            end else if (tick) begin
               cnt_nx = cnt - 4'd1;
            end
         end
         default: state_nx = MAIN_HOLD;
      endcase
   end

   // Outputs decoded from the registered state and grant
   always_comb begin
      sif.phase       = PH_MAIN_GO;
      sif.phase_valid = 1'b0;
      case (state)
         ISSUE: begin
            sif.phase       = grant + 3'd1;
            sif.phase_valid = 1'b1;
         end
         SERVE:   sif.phase = grant + 3'd1;
         ALL_RED: sif.phase = PH_ALL_STOP;
         default: sif.phase = PH_MAIN_GO;
      endcase
   end

   assign busy       = (state == ISSUE) || (state == SERVE);
   assign dbg_state  = state;
   assign dbg_cnt    = cnt;
   assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_phase_scheduler.sv
// Self-checking bench for phase_scheduler: directed sequences with a
// scoreboard of expected offered phase codes checked by a separate monitor.
module tb_phase_scheduler;
   import traffic_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic [4:0] req_in;
   logic [4:0] pending;
   logic       busy;
   state_t     dbg_state;
   logic [3:0] dbg_cnt;
   logic [2:0] dbg_rr_ptr;

   phase_scheduler_if sif ();

   phase_scheduler #(.MIN_MAIN_S(6), .ALLRED_S(3), .N_REQ(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .req_in     (req_in),
      .sif        (sif),
      .pending    (pending),
      .busy       (busy),
      .dbg_state  (dbg_state),
      .dbg_cnt    (dbg_cnt),
      .dbg_rr_ptr (dbg_rr_ptr)
   );

   // Clock
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [2:0] exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: each new offer is compared against the next expected phase
   logic valid_q = 1'b0;
   always @(negedge clk) begin
      if (sif.phase_valid && !valid_q) begin
         if (exp_q.size() == 0) begin
            check("unexpected_offer", int'(sif.phase), -1);
         end else begin
            check("offer_phase", int'(sif.phase), int'(exp_q.pop_front()));
         end
      end
      valid_q = sif.phase_valid;
   end

   // Driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_once();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; tick = 1'b0; req_in = '0;
      sif.phase_ack = 1'b0; sif.phase_done = 1'b0;
      step(); step();
      reset = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!sif.phase_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("offer_arrives", int'(sif.phase_valid), 1);
   endtask

   task automatic serve_round();
      wait_valid();
      sif.phase_ack = 1'b1;
      step();
      sif.phase_ack = 1'b0;
      sif.phase_done = 1'b1;
      step();
      sif.phase_done = 1'b0;
      check("round_allred_phase", int'(sif.phase), 7);
      check("round_allred_state", int'(dbg_state), int'(ALL_RED));
      repeat (3) tick_once();
      step();
      check("round_main_again", int'(sif.phase), 0);
      repeat (6) tick_once();
   endtask

   int   bad;
   logic [2:0] held;

   initial begin
      // Test 1: idle after reset, counter saturates
      do_reset();
      check("rst_phase", int'(sif.phase), 0);
      check("rst_valid", int'(sif.phase_valid), 0);
      check("rst_pending", int'(pending), 0);
      check("rst_cnt", int'(dbg_cnt), 6);
      check("rst_busy", int'(busy), 0);
      check("rst_state", int'(dbg_state), int'(MAIN_HOLD));
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick_once();
         step();
         if (sif.phase_valid !== 1'b0 || sif.phase !== 3'd0) bad++;
      end
      check("idle_no_offer", bad, 0);
      check("idle_cnt_sat", int'(dbg_cnt), 0);
      check("idle_pending", int'(pending), 0);

      // Test 2: single cross-traffic request through a full round
      do_reset();
      exp_q.push_back(3'd3);
      tick_once();
      tick = 1'b1; req_in = 5'b00100;
      step();
      tick = 1'b0; req_in = '0;
      check("t2_pending", int'(pending), 5'b00100);
      check("t2_cnt", int'(dbg_cnt), 4);
      for (int i = 0; i < 4; i++) tick_once();
      check("t2_hold_no_offer", int'(sif.phase_valid), 0);
      step();
      check("t2_valid", int'(sif.phase_valid), 1);
      check("t2_busy_issue", int'(busy), 1);
      repeat (3) step();
      check("t2_valid_held", int'(sif.phase_valid), 1);
      sif.phase_ack = 1'b1;
      step();
      sif.phase_ack = 1'b0;
      check("t2_serve_state", int'(dbg_state), int'(SERVE));
      check("t2_serve_valid", int'(sif.phase_valid), 0);
      check("t2_serve_phase", int'(sif.phase), 3);
      sif.phase_done = 1'b1;
      step();
      sif.phase_done = 1'b0;
      check("t2_done_pending", int'(pending), 0);
      check("t2_allred_phase", int'(sif.phase), 7);
      check("t2_allred_cnt", int'(dbg_cnt), 3);
      repeat (3) tick_once();
      check("t2_allred_last", int'(sif.phase), 7);
      step();
      check("t2_main_phase", int'(sif.phase), 0);
      check("t2_main_cnt", int'(dbg_cnt), 6);

      // Test 3: round-robin over 10011 from pointer 0
      do_reset();
      repeat (6) tick_once();
      exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd5);
      req_in = 5'b10011;
      step();
      req_in = '0;
      serve_round();
      check("t3_ptr1", int'(dbg_rr_ptr), 1);
      serve_round();
      check("t3_ptr2", int'(dbg_rr_ptr), 2);
      serve_round();
      check("t3_ptr_wrap", int'(dbg_rr_ptr), 0);
      check("t3_pending", int'(pending), 0);

      // Test 4: offer held while unacknowledged; stray done ignored
      do_reset();
      repeat (6) tick_once();
      exp_q.push_back(3'd2);
      req_in = 5'b00010;
      step();
      req_in = '0;
      wait_valid();
      held = sif.phase;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         sif.phase_done = (i == 20);
         step();
         if (sif.phase_valid !== 1'b1 || sif.phase !== held) bad++;
      end
      sif.phase_done = 1'b0;
      check("t4_stable", bad, 0);
      check("t4_state", int'(dbg_state), int'(ISSUE));
      check("t4_pending", int'(pending), 5'b00010);

      // Test 5: sensor held through done: one-cycle clear then re-latch
      do_reset();
      repeat (6) tick_once();
      exp_q.push_back(3'd1);
      req_in = 5'b00001;
      wait_valid();
      sif.phase_ack = 1'b1;
      step();
      sif.phase_ack = 1'b0;
      sif.phase_done = 1'b1;
      step();
      sif.phase_done = 1'b0;
      check("t5_cleared", int'(pending[0]), 0);
      step();
      check("t5_relatched", int'(pending[0]), 1);
      req_in = '0;

      // Test 6: reset in SERVE withdraws everything and restarts the hold
      do_reset();
      repeat (6) tick_once();
      exp_q.push_back(3'd4);
      req_in = 5'b01000;
      step();
      req_in = '0;
      wait_valid();
      sif.phase_ack = 1'b1;
      step();
      sif.phase_ack = 1'b0;
      check("t6_in_serve", int'(dbg_state), int'(SERVE));
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t6_state", int'(dbg_state), int'(MAIN_HOLD));
      check("t6_phase", int'(sif.phase), 0);
      check("t6_valid", int'(sif.phase_valid), 0);
      check("t6_pending", int'(pending), 0);
      check("t6_busy", int'(busy), 0);
      check("t6_cnt", int'(dbg_cnt), 6);
      repeat (5) tick_once();
      check("t6_cnt_after5", int'(dbg_cnt), 1);
      tick_once();
      check("t6_cnt_after6", int'(dbg_cnt), 0);
      step();
      check("t6_no_offer", int'(sif.phase_valid), 0);

      // Report
      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
